mem_arbiter: RTL and testbench

- Shares one 32-bit SRAM-style memory port between the instruction-fetch requester (F stage) and the data-access requester (M stage) of the pipelined MIPS core.
- Sits between the core's pcF/instrF and aluoutM/writedataM/memwriteM/readdataM interfaces and a single memory with a req/ack handshake.
- Arbitrates with data priority and a bounded-starvation guard for fetch.
- Latches each transaction, returns read data, and generates per-side stall signals.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_priority.sv | 54 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Imported by mem_arb_priority and mem_arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INST = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_INST = 2'b01,
    GNT_DATA = 2'b10
  } grant_e;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant decision for the shared memory port: data first, but a waiting fetch
// is forced through after MAX_DATA_RUN back-to-back data grants.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int RUN_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_req_i,
  input  logic       data_req_i,
  input  logic       idle_i,
  output logic [1:0] grant_o
);

  localparam logic [RUN_W-1:0] MaxRun = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_q, run_d;
  logic             forced;
  grant_e           grant;

  // The run counter only moves on an actual grant, so it measures how many
  // data accesses in a row have overtaken a pending fetch.
  always_comb begin
    forced = (MAX_DATA_RUN != 0) && (run_q == MaxRun) && inst_req_i;
    grant  = GNT_NONE;
    run_d  = run_q;
    if (idle_i) begin
      if (data_req_i && !forced) begin
        grant = GNT_DATA;
        if (inst_req_i) begin
          run_d = (run_q == MaxRun) ? run_q : run_q + 1'b1;
        end else begin
          run_d = '0;
        end
      end else if (inst_req_i) begin
        grant = GNT_INST;
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign grant_o = grant;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM-style req/ack memory port between the MIPS fetch and data
// stages; latches each transaction and produces per-side ready/stall signals.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int RUN_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic              stall_inst,
  output logic              stall_data,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q, state_d;
  logic              memReq_q, memReq_d;
  logic [3:0]        memWen_q, memWen_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic [31:0]       instRdata_q, instRdata_d;
  logic [31:0]       dataRdata_q, dataRdata_d;
  logic              instReady_q, instReady_d;
  logic              dataReady_q, dataReady_d;
  logic [1:0]        grant;

  mem_arb_priority #(
    .MAX_DATA_RUN(MAX_DATA_RUN),
    .RUN_W       (RUN_W)
  ) u_priority (
    .clk       (clk),
    .rst       (rst),
    .inst_req_i(inst_req),
    .data_req_i(data_req),
    .idle_i    (state_q == IDLE),
    .grant_o   (grant)
  );

  // Ready flags are set on the ack edge, so they are high exactly in DONE.
  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memWen_d    = memWen_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    instRdata_d = instRdata_q;
    dataRdata_d = dataRdata_q;
    instReady_d = 1'b0;
    dataReady_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant == GNT_DATA) begin
          state_d    = DATA;
          memReq_d   = 1'b1;
          memWen_d   = data_wen;
          memAddr_d  = data_addr;
          memWdata_d = data_wdata;
        end else if (grant == GNT_INST) begin
          state_d    = INST;
          memReq_d   = 1'b1;
          memWen_d   = 4'b0000;
          memAddr_d  = inst_addr;
          memWdata_d = 32'h0;
        end
      end
      INST: begin
        if (mem_ack) begin
          instRdata_d = mem_rdata;
          instReady_d = 1'b1;
          memReq_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DATA: begin
        if (mem_ack) begin
          if (memWen_q == 4'b0000) begin
            dataRdata_d = mem_rdata;
          end
          dataReady_d = 1'b1;
          memReq_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWen_q    <= 4'b0000;
      memAddr_q   <= '0;
      memWdata_q  <= 32'h0;
      instRdata_q <= 32'h0;
      dataRdata_q <= 32'h0;
      instReady_q <= 1'b0;
      dataReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      memReq_q    <= memReq_d;
      memWen_q    <= memWen_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      instRdata_q <= instRdata_d;
      dataRdata_q <= dataRdata_d;
      instReady_q <= instReady_d;
      dataReady_q <= dataReady_d;
    end
  end

  assign mem_req    = memReq_q;
  assign mem_wen    = memWen_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign inst_rdata = instRdata_q;
  assign data_rdata = dataRdata_q;
  assign inst_ready = instReady_q;
  assign data_ready = dataReady_q;
  assign stall_inst = inst_req & ~instReady_q;
  assign stall_data = data_req & ~dataReady_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model plus a
// simple memory responder, with directed scenarios and literal expectations.
module tb_mem_arbiter;

  localparam int MaxRun = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        stall_inst;
  logic        stall_data;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  bit respEnable = 1'b1;
  int ackDelay = 0;
  int waitCnt = 0;

  // grant log: 1 = fetch, 2 = data
  int         gKind[$];
  logic [3:0] gWen[$];
  logic       prevReq = 1'b0;

  mem_arbiter #(.MAX_DATA_RUN(MaxRun), .RUN_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_ready(inst_ready),
    .data_req  (data_req),
    .data_wen  (data_wen),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ready(data_ready),
    .stall_inst(stall_inst),
    .stall_data(stall_data),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory contents: the boot word at the reset vector, a fixed pattern elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C08ABCD;
    return a ^ 32'h5A5A5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wen   = dw;
    data_addr  = da;
    data_wdata = dd;
  endtask

  task automatic waitReady(input bit wantInst, input int budget, output int cycles);
    cycles = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (wantInst ? inst_ready : data_ready) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) checkOutput(wantInst ? "instReadyTimeout" : "dataReadyTimeout", 32'd0, 32'd1);
  endtask

  // Memory responder: acks ackDelay cycles after it first sees mem_req.
  always @(negedge clk) begin
    if (respEnable) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(mem_addr);
          waitCnt   = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end else begin
      waitCnt = 0;
    end
  end

  // Transaction-level model: one outstanding access, a one-cycle completion
  // pulse, and a count of data grants that overtook a waiting fetch.
  int          mBusy = 0;
  int          mPulse = 0;
  int          mRun = 0;
  logic [31:0] mAddr = 32'h0;
  logic [31:0] mWdata = 32'h0;
  logic [31:0] mInstR = 32'h0;
  logic [31:0] mDataR = 32'h0;
  logic [3:0]  mWen = 4'h0;

  always @(posedge clk) begin
    bit starve;
    if (rst) begin
      mBusy = 0; mPulse = 0; mRun = 0;
      mAddr = 32'h0; mWdata = 32'h0; mWen = 4'h0;
      mInstR = 32'h0; mDataR = 32'h0;
    end else if (mPulse != 0) begin
      mPulse = 0;
    end else if (mBusy != 0) begin
      if (mem_ack) begin
        if (mBusy == 1) mInstR = mem_rdata;
        else if (mWen == 4'h0) mDataR = mem_rdata;
        mPulse = mBusy;
        mBusy  = 0;
      end
    end else begin
      starve = (MaxRun > 0) && (mRun >= MaxRun) && inst_req;
      if (data_req && !starve) begin
        mBusy = 2; mAddr = data_addr; mWen = data_wen; mWdata = data_wdata;
        mRun  = inst_req ? ((mRun < MaxRun) ? mRun + 1 : mRun) : 0;
      end else if (inst_req) begin
        mBusy = 1; mAddr = inst_addr; mWen = 4'h0; mWdata = 32'h0;
        mRun  = 0;
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("mem_req",    32'(mem_req),    32'(mBusy != 0));
      checkOutput("mem_wen",    32'(mem_wen),    32'(mWen));
      checkOutput("mem_addr",   mem_addr,        mAddr);
      checkOutput("mem_wdata",  mem_wdata,       mWdata);
      checkOutput("inst_ready", 32'(inst_ready), 32'(mPulse == 1));
      checkOutput("data_ready", 32'(data_ready), 32'(mPulse == 2));
      checkOutput("inst_rdata", inst_rdata,      mInstR);
      checkOutput("data_rdata", data_rdata,      mDataR);
      checkOutput("stall_inst", 32'(stall_inst), 32'(inst_req && mPulse != 1));
      checkOutput("stall_data", 32'(stall_data), 32'(data_req && mPulse != 2));
    end
    if (mem_req && !prevReq) begin
      gKind.push_back((mem_addr == 32'h100) ? 2 : 1);
      gWen.push_back(mem_wen);
    end
    prevReq = mem_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int k;
    int expKinds[6];
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("resetMemReq", 32'(mem_req), 32'd0);
    checkOutput("resetMemAddr", mem_addr, 32'd0);
    checkOutput("resetInstRdata", inst_rdata, 32'd0);

    // 1: single fetch from the reset vector
    $display("[TB] test 1: single fetch");
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t1MemAddr", mem_addr, 32'hBFC00000);
    checkOutput("t1MemWen", 32'(mem_wen), 32'd0);
    checkOutput("t1StallHigh", 32'(stall_inst), 32'd1);
    waitReady(1'b1, 20, c);
    checkOutput("t1Latency", c, 32'd1);
    checkOutput("t1Rdata", inst_rdata, 32'h3C08ABCD);
    checkOutput("t1StallLow", 32'(stall_inst), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t1PulseEnds", 32'(inst_ready), 32'd0);
    repeat (2) @(negedge clk);

    // 2: store and fetch collide; store goes first
    $display("[TB] test 2: store/fetch collision");
    gKind.delete(); gWen.delete();
    applyStimulus(1'b1, 32'h400, 1'b1, 4'b0011, 32'h100, 32'h1234);
    waitReady(1'b0, 20, c);
    checkOutput("t2StoreRdata", data_rdata, 32'h0);
    applyStimulus(1'b1, 32'h400, 1'b0, 4'h0, 32'h0, 32'h0);
    waitReady(1'b1, 20, c);
    checkOutput("t2FetchRdata", inst_rdata, 32'h5A5A5E5A);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("t2Grants", gKind.size(), 32'd2);
    if (gKind.size() == 2) begin
      checkOutput("t2First", gKind[0], 32'd2);
      checkOutput("t2FirstWen", 32'(gWen[0]), 32'b0011);
      checkOutput("t2Second", gKind[1], 32'd1);
    end

    // 3: starvation guard with both requests held
    $display("[TB] test 3: starvation guard");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gKind.delete(); gWen.delete();
    applyStimulus(1'b1, 32'h400, 1'b1, 4'h0, 32'h100, 32'h0);
    k = 0;
    while (gKind.size() < 6 && k < 80) begin
      @(negedge clk);
      k++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("t3Grants", gKind.size(), 32'd6);
    expKinds = '{2, 2, 2, 2, 1, 2};
    for (int i = 0; i < 6; i++) begin
      if (i < gKind.size()) checkOutput($sformatf("t3Grant%0d", i), gKind[i], expKinds[i]);
    end
    checkOutput("t3DataRdata", data_rdata, 32'h5A5A5B5A);
    checkOutput("t3InstRdata", inst_rdata, 32'h5A5A5E5A);

    // 4: five wait states while requester inputs toggle
    $display("[TB] test 4: wait states");
    ackDelay = 5;
    applyStimulus(1'b1, 32'h800, 1'b0, 4'hF, 32'h200, 32'hFFFF);
    k = 0;
    c = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (inst_ready) begin
        c = 1;
        break;
      end
      checkOutput("t4HoldAddr", mem_addr, 32'h800);
      checkOutput("t4HoldWen", 32'(mem_wen), 32'd0);
      inst_addr  = ~inst_addr;
      data_addr  = data_addr + 32'd4;
      data_wdata = ~data_wdata;
      data_wen   = ~data_wen;
      data_req   = ~data_req;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("t4ReadySeen", c, 32'd1);
    checkOutput("t4Latency", k, 32'd7);
    checkOutput("t4Rdata", inst_rdata, 32'h5A5A525A);
    ackDelay = 0;
    repeat (2) @(negedge clk);

    // 5: reset while a data access is outstanding, then a late ack
    $display("[TB] test 5: reset mid-transaction");
    respEnable = 1'b0;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h300, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("t5Busy", 32'(mem_req), 32'd1);
    checkOutput("t5BusyAddr", mem_addr, 32'h300);
    rst = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    checkOutput("t5MemReq", 32'(mem_req), 32'd0);
    checkOutput("t5MemAddr", mem_addr, 32'd0);
    checkOutput("t5InstRdata", inst_rdata, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5NoReady", 32'(data_ready), 32'd0);
      checkOutput("t5DataRdata", data_rdata, 32'd0);
      @(negedge clk);
    end
    respEnable = 1'b1;
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
    waitReady(1'b1, 10, c);
    checkOutput("t5FetchLatency", c, 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // 6: spurious ack while idle
    $display("[TB] test 6: spurious ack");
    respEnable = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t6MemReq", 32'(mem_req), 32'd0);
      checkOutput("t6InstReady", 32'(inst_ready), 32'd0);
      checkOutput("t6DataReady", 32'(data_ready), 32'd0);
      checkOutput("t6InstRdata", inst_rdata, 32'h3C08ABCD);
      checkOutput("t6DataRdata", data_rdata, 32'd0);
    end
    mem_ack = 1'b0;
    respEnable = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    waitReady(1'b0, 10, c);
    checkOutput("t6LoadLatency", c, 32'd2);
    checkOutput("t6LoadRdata", data_rdata, 32'h5A5A5B5A);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
